// File: rtl/mage_pkg.sv
// Shared MAGE types and widths, including the hardware-loop generator state
// encoding and loop-count width.
package mage_pkg;

    localparam int unsigned N_LP         = 4;
    localparam int unsigned LOG2_N_LP    = $clog2(N_LP);
    localparam int unsigned NBIT_LP_IV   = 8;
    localparam int unsigned NBIT_II      = 4;
    localparam int unsigned NBIT_N_LOOPS = LOG2_N_LP + 1;

    typedef struct packed {
        logic [NBIT_LP_IV-1:0] iv;
        logic [NBIT_LP_IV-1:0] fv;
        logic [NBIT_LP_IV-1:0] inc;
    } loop_vars_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } hwlp_state_t;

endpackage

// File: rtl/mage_hwlp_lp_cnt.sv
// One loop counter of the hardware-loop nest: latched iv/fv/inc, the current
// value, and the end-of-loop flag derived from the next step.
module mage_hwlp_lp_cnt #(
    parameter int unsigned NBIT_LP_IV = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [NBIT_LP_IV-1:0] iv_i,
    input  logic [NBIT_LP_IV-1:0] fv_i,
    input  logic [NBIT_LP_IV-1:0] inc_i,
    input  logic                  step_i,
    input  logic                  reload_i,
    output logic [NBIT_LP_IV-1:0] value_o,
    output logic                  at_end_o
);

    logic [NBIT_LP_IV-1:0] iv_q, fv_q, inc_q, cur_q;
    logic [NBIT_LP_IV-1:0] inc_eff;
    logic [NBIT_LP_IV:0]   next_val;

    // Extra bit keeps the carry so an overflowing step ends the loop instead of wrapping.
    always_comb begin
        inc_eff  = (inc_q == '0) ? NBIT_LP_IV'(1) : inc_q;
        next_val = {1'b0, cur_q} + {1'b0, inc_eff};
    end

    assign at_end_o = next_val[NBIT_LP_IV] | (next_val[NBIT_LP_IV-1:0] > fv_q);
    assign value_o  = cur_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iv_q  <= '0;
            fv_q  <= '0;
            inc_q <= '0;
            cur_q <= '0;
        end else if (load_i) begin
            iv_q  <= iv_i;
            fv_q  <= fv_i;
            inc_q <= inc_i;
            cur_q <= iv_i;
        end else if (reload_i) begin
            cur_q <= iv_q;
        end else if (step_i) begin
            cur_q <= next_val[NBIT_LP_IV-1:0];
        end
    end

endmodule

// File: rtl/mage_hwlp_iv_gen.sv
// Hardware-loop iteration-variable generator: steps an N_LP-deep nest odometer-style
// and emits one tuple per handshake. MAGE_HWLP_PERF_EN adds a stall counter output.
module mage_hwlp_iv_gen #(
    parameter int unsigned N_LP       = mage_pkg::N_LP,
    parameter int unsigned NBIT_LP_IV = mage_pkg::NBIT_LP_IV,
    parameter int unsigned NBIT_II    = mage_pkg::NBIT_II
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  mage_pkg::loop_vars_t [N_LP-1:0]     loop_cfg_i,
    input  logic [$clog2(N_LP):0]               n_loops_i,
    input  logic [NBIT_II-1:0]                  ii_i,
    output logic [N_LP-1:0][NBIT_LP_IV-1:0]     iv_o,
    output logic [N_LP-1:0]                     lp_end_o,
    output logic                                iv_valid_o,
    input  logic                                iv_ready_i,
    output logic                                last_o,
    output logic                                busy_o,
`ifdef MAGE_HWLP_PERF_EN
    output logic [15:0]                         perf_stall_o,
`endif
    output logic                                done_o
);

    import mage_pkg::*;

    localparam int unsigned NbitN = $clog2(N_LP) + 1;

    hwlp_state_t         state_q, state_d;
    logic [NBIT_II-1:0]  ii_q, gap_q, gap_d;
    logic [N_LP-1:0]     active_q, active_d;
    logic [N_LP-1:0]     at_end, lp_end, below, step, reload;
    logic [NbitN-1:0]    n_eff;
    logic                load, hs, last_raw, adv, acc;

    assign load = (state_q == IDLE) && start_i;
    assign hs   = (state_q == RUN) && iv_ready_i;

    // Clamp the loop count into [1, N_LP] and turn it into an active-loop mask.
    always_comb begin
        n_eff = n_loops_i;
        if (n_loops_i == '0) begin
            n_eff = NbitN'(1);
        end else if (n_loops_i > NbitN'(N_LP)) begin
            n_eff = NbitN'(N_LP);
        end
        for (int k = 0; k < N_LP; k++) begin
            active_d[k] = (NbitN'(k) < n_eff);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= '0;
            ii_q     <= '0;
        end else if (load) begin
            active_q <= active_d;
            ii_q     <= (ii_i == '0) ? NBIT_II'(1) : ii_i;
        end
    end

    for (genvar k = 0; k < N_LP; k++) begin : g_lp
        mage_hwlp_lp_cnt #(
            .NBIT_LP_IV (NBIT_LP_IV)
        ) u_lp_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .load_i   (load),
            .iv_i     (loop_cfg_i[k].iv),
            .fv_i     (loop_cfg_i[k].fv),
            .inc_i    (loop_cfg_i[k].inc),
            .step_i   (step[k]),
            .reload_i (reload[k]),
            .value_o  (iv_o[k]),
            .at_end_o (at_end[k])
        );
    end

    // Loop k moves only when every lower loop has finished; finished loops wrap to iv.
    always_comb begin
        lp_end   = at_end | ~active_q;
        last_raw = &lp_end;
        adv      = hs && !last_raw;
        acc      = 1'b1;
        for (int k = 0; k < N_LP; k++) begin
            below[k] = acc;
            acc      = acc & lp_end[k];
        end
        step   = adv ? (below & ~lp_end) : '0;
        reload = adv ? (below & lp_end) : '0;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (iv_ready_i) begin
                    if (last_raw) begin
                        state_d = DONE;
                    end else if (ii_q > NBIT_II'(1)) begin
                        state_d = GAP;
                        gap_d   = ii_q - NBIT_II'(2);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = RUN;
                end else begin
                    gap_d = gap_q - NBIT_II'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    assign iv_valid_o = (state_q == RUN);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    // Counters reset to 0, which reads as "at end"; mask so idle outputs stay 0.
    assign lp_end_o   = busy_o ? lp_end : '0;
    assign last_o     = busy_o && last_raw;

`ifdef MAGE_HWLP_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (load) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && !iv_ready_i && (stall_q != 16'hffff)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign perf_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_mage_hwlp_iv_gen.sv
// Self-checking bench for mage_hwlp_iv_gen: table-driven loop nests with a tuple
// scoreboard, plus hand-written backpressure and mid-run reset sequences.
module tb_mage_hwlp_iv_gen;

    import mage_pkg::*;

    logic                            clk     = 1'b0;
    logic                            rst_n   = 1'b0;
    logic                            start   = 1'b0;
    logic                            ready   = 1'b1;
    loop_vars_t [N_LP-1:0]           cfg_in  = '0;
    logic [NBIT_N_LOOPS-1:0]         n_loops = '0;
    logic [NBIT_II-1:0]              ii      = '0;
    logic [N_LP-1:0][NBIT_LP_IV-1:0] iv;
    logic [N_LP-1:0]                 lp_end;
    logic                            valid, last, busy, done;
`ifdef MAGE_HWLP_PERF_EN
    logic [15:0]                     perf;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mage_hwlp_iv_gen dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .loop_cfg_i   (cfg_in),
        .n_loops_i    (n_loops),
        .ii_i         (ii),
        .iv_o         (iv),
        .lp_end_o     (lp_end),
        .iv_valid_o   (valid),
        .iv_ready_i   (ready),
        .last_o       (last),
        .busy_o       (busy),
`ifdef MAGE_HWLP_PERF_EN
        .perf_stall_o (perf),
`endif
        .done_o       (done)
    );

    typedef struct packed {
        logic [2:0] n_loops;
        logic [3:0] ii;
        logic [7:0] iv0, fv0, inc0, iv1, fv1, inc1;
        logic [3:0] gap;
    } cfg_t;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] e0, e1;
        logic [1:0] ee;
        logic       last;
    } tup_t;

    typedef struct packed {
        logic [31:0] iv;
        logic [3:0]  lp_end;
        logic        last;
    } exp_t;

    cfg_t cfgs[5];
    tup_t tups[18];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_tuple();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got tuple 0x%0h, expected no further tuple", iv);
        end else begin
            e = sb.pop_front();
            check("tuple_iv", iv, e.iv);
            check("tuple_lp_end", 32'(lp_end), 32'(e.lp_end));
            check("tuple_last", 32'(last), 32'(e.last));
        end
    endtask

    // Called at a negedge with the DUT idle; leaves the bench one cycle later.
    task automatic launch(input int v);
        cfg_t c;
        c         = cfgs[v];
        cfg_in    = '0;
        cfg_in[0] = '{iv: c.iv0, fv: c.fv0, inc: c.inc0};
        cfg_in[1] = '{iv: c.iv1, fv: c.fv1, inc: c.inc1};
        n_loops   = c.n_loops;
        ii        = c.ii;
        start     = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (int'(tups[i].id) == v) begin
                sb.push_back('{iv: {16'd0, tups[i].e1, tups[i].e0},
                               lp_end: {2'b11, tups[i].ee}, last: tups[i].last});
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("first_valid", 32'(valid), 32'd1);
    endtask

    task automatic drain(input int gap);
        int last_hs;
        bit finished;
        last_hs  = -1;
        finished = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            if (valid && ready) begin
                if (last_hs >= 0) check("hs_spacing", 32'(cyc - last_hs), 32'(gap));
                last_hs = cyc;
                check_tuple();
                if (last) begin
                    @(negedge clk);
                    check("done_pulse", 32'(done), 32'd1);
                    check("busy_in_done", 32'(busy), 32'd1);
                    @(negedge clk);
                    check("done_clear", 32'(done), 32'd0);
                    check("busy_clear", 32'(busy), 32'd0);
                    finished = 1'b1;
                end
            end else begin
                check("no_early_done", 32'(done), 32'd0);
            end
            if (!finished) @(negedge clk);
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got no final handshake, expected one within 300 cycles");
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        // n_loops, ii, iv0, fv0, inc0, iv1, fv1, inc1, expected handshake spacing
        cfgs[0] = '{3'd2, 4'd1, 8'd0,   8'd2,   8'd1, 8'd0, 8'd1,   8'd1, 4'd1};
        cfgs[1] = '{3'd2, 4'd3, 8'd0,   8'd2,   8'd1, 8'd0, 8'd1,   8'd1, 4'd3};
        cfgs[2] = '{3'd1, 4'd1, 8'd250, 8'd255, 8'd4, 8'd7, 8'd200, 8'd1, 4'd1};
        cfgs[3] = '{3'd0, 4'd2, 8'd5,   8'd3,   8'd0, 8'd9, 8'd50,  8'd1, 4'd2};
        cfgs[4] = '{3'd2, 4'd0, 8'd3,   8'd7,   8'd2, 8'd1, 8'd1,   8'd0, 4'd1};
        // id, iv0, iv1, {end1, end0}, last
        tups[0]  = '{4'd0, 8'd0,   8'd0, 2'b00, 1'b0};
        tups[1]  = '{4'd0, 8'd1,   8'd0, 2'b00, 1'b0};
        tups[2]  = '{4'd0, 8'd2,   8'd0, 2'b01, 1'b0};
        tups[3]  = '{4'd0, 8'd0,   8'd1, 2'b10, 1'b0};
        tups[4]  = '{4'd0, 8'd1,   8'd1, 2'b10, 1'b0};
        tups[5]  = '{4'd0, 8'd2,   8'd1, 2'b11, 1'b1};
        tups[6]  = '{4'd1, 8'd0,   8'd0, 2'b00, 1'b0};
        tups[7]  = '{4'd1, 8'd1,   8'd0, 2'b00, 1'b0};
        tups[8]  = '{4'd1, 8'd2,   8'd0, 2'b01, 1'b0};
        tups[9]  = '{4'd1, 8'd0,   8'd1, 2'b10, 1'b0};
        tups[10] = '{4'd1, 8'd1,   8'd1, 2'b10, 1'b0};
        tups[11] = '{4'd1, 8'd2,   8'd1, 2'b11, 1'b1};
        tups[12] = '{4'd2, 8'd250, 8'd7, 2'b10, 1'b0};
        tups[13] = '{4'd2, 8'd254, 8'd7, 2'b11, 1'b1};
        tups[14] = '{4'd3, 8'd5,   8'd9, 2'b11, 1'b1};
        tups[15] = '{4'd4, 8'd3,   8'd1, 2'b10, 1'b0};
        tups[16] = '{4'd4, 8'd5,   8'd1, 2'b10, 1'b0};
        tups[17] = '{4'd4, 8'd7,   8'd1, 2'b11, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_iv", iv, 32'd0);
        check("reset_lp_end", 32'(lp_end), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_last", 32'(last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            launch(v);
            drain(int'(cfgs[v].gap));
        end

        // Backpressure on the second tuple, with a stray start and config change mid-run.
        launch(0);
        check_tuple();
        @(negedge clk);
        held      = iv;
        ready     = 1'b0;
        start     = 1'b1;
        cfg_in[0] = '{iv: 8'd100, fv: 8'd200, inc: 8'd3};
        n_loops   = 3'd1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_hold", iv, held);
        end
        ready = 1'b1;
        drain(1);
`ifdef MAGE_HWLP_PERF_EN
        check("perf_stall", 32'(perf), 32'd5);
`endif

        // Reset while the third tuple is presented, then replay from the top.
        launch(0);
        check_tuple();
        @(negedge clk);
        check_tuple();
        @(negedge clk);
        check("rst_pre_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_iv", iv, 32'd0);
        check("rst_lp_end", 32'(lp_end), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        sb.delete();
        @(negedge clk);
        check("rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle_busy", 32'(busy), 32'd0);
        check("rst_idle_done", 32'(done), 32'd0);
        launch(0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
